adc_serial_responder: RTL and testbench



---
 rtl/adc_serial_responder.sv | 162 ++++++++++++++++
 tb/tb_adc_serial_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/adc_serial_responder.sv
// ADC0831-style serial responder: captures sample_value on cs_n fall and
// shifts a null bit plus the sample MSB-first on falling edges of clk_adc.
module adc_serial_responder #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_value,
    input  logic              cs_n,
    input  logic              clk_adc,
    output logic              data_out,
    output logic              data_oe,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        NULL_BIT = 3'd2,
        SHIFT    = 3'd3,
        DONE     = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] ck_sync;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic                   cs_hist;
    logic                   ck_hist;
    logic                   armed;

    logic cs_fall;
    logic cs_rise;
    logic ck_fall;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              data_out_d, data_oe_d, busy_d, done_d, err_d;

    // Synchronizers plus history flops; sync_vld marks when the cs_n chain
    // holds real pin samples so a cs_n held low through reset cannot start a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync  <= '1;
            ck_sync  <= '0;
            sync_vld <= '0;
            cs_hist  <= 1'b1;
            ck_hist  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            ck_sync  <= {ck_sync[SYNC_STAGES-2:0], clk_adc};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            cs_hist  <= cs_sync[SYNC_STAGES-1];
            ck_hist  <= ck_sync[SYNC_STAGES-1];
            if (sync_vld[SYNC_STAGES-1] && cs_sync[SYNC_STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign cs_fall = armed & cs_hist & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise = ~cs_hist & cs_sync[SYNC_STAGES-1];
    assign ck_fall = ck_hist & ~ck_sync[SYNC_STAGES-1];

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            data_out   <= 1'b0;
            data_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            data_out   <= data_out_d;
            data_oe    <= data_oe_d;
            busy       <= busy_d;
            frame_done <= done_d;
            frame_err  <= err_d;
        end
    end

    // Next-state and next-output logic; a cs_n rise overrides any clock edge.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        data_out_d = data_out;
        data_oe_d  = data_oe;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (state_q != IDLE && cs_rise) begin
            state_d    = IDLE;
            data_out_d = 1'b0;
            data_oe_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = (state_q == DONE);
            err_d      = (state_q != DONE);
        end else begin
            unique case (state_q)
                IDLE: begin
                    data_out_d = 1'b0;
                    data_oe_d  = 1'b0;
                    busy_d     = 1'b0;
                    if (cs_fall) begin
                        shift_d = sample_value;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (ck_fall) begin
                        data_oe_d  = 1'b1;
                        data_out_d = 1'b0;
                        state_d    = NULL_BIT;
                    end
                end
                NULL_BIT: begin
                    if (ck_fall) begin
                        data_out_d = shift_q[DATA_W-1];
                        shift_d    = {shift_q[DATA_W-2:0], 1'b0};
                        cnt_d      = CNT_W'(DATA_W - 1);
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (ck_fall) begin
                        if (cnt_q == '0) begin
                            data_out_d = 1'b0;
                            state_d    = DONE;
                        end else begin
                            data_out_d = shift_q[DATA_W-1];
                            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
                            cnt_d      = cnt_q - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    data_oe_d  = 1'b1;
                    data_out_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder acting as the serial-link initiator.
module tb_adc_serial_responder;

    localparam int unsigned HALF = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sample_value;
    logic       cs_n;
    logic       clk_adc;
    logic       data_out;
    logic       data_oe;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    logic [15:0] rx;
    logic        oe_all;
    logic        act;

    adc_serial_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_value (sample_value),
        .cs_n         (cs_n),
        .clk_adc      (clk_adc),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output and any overlap.
    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Open a frame, swap sample_value after capture, then clock 'periods' cycles.
    task automatic run_frame(input logic [7:0] val, input logic [7:0] late_val,
                             input int periods, output logic [15:0] bits,
                             output logic oe_ok);
        sample_value = val;
        cs_n = 1'b0;
        wait_clk(HALF);
        sample_value = late_val;
        chk("settle_oe", 32'(data_oe), 32'd0);
        chk("settle_busy", 32'(busy), 32'd1);
        bits  = '0;
        oe_ok = 1'b1;
        for (int p = 0; p < periods; p++) begin
            clk_adc = 1'b0;
            wait_clk(HALF);
            clk_adc = 1'b1;
            bits  = {bits[14:0], data_out};
            oe_ok = oe_ok & data_oe;
            wait_clk(HALF);
        end
    endtask

    task automatic end_frame(input string tag);
        cs_n = 1'b1;
        wait_clk(3);
        chk({tag, "_end_oe"}, 32'(data_oe), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        wait_clk(HALF);
    endtask

    // Toggle clk_adc without a frame and record any output activity.
    task automatic toggle_only(input int periods, output logic any);
        any = 1'b0;
        for (int p = 0; p < 2 * periods; p++) begin
            clk_adc = ~clk_adc;
            for (int c = 0; c < int'(HALF); c++) begin
                @(negedge clk);
                any = any | data_oe | busy | data_out | frame_done | frame_err;
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        cs_n         = 1'b1;
        clk_adc      = 1'b1;
        sample_value = 8'h00;
        wait_clk(3);
        chk("reset_outs", 32'({data_out, data_oe, busy, frame_done, frame_err}), 32'd0);
        reset_n = 1'b1;
        wait_clk(6);
        chk("post_reset_outs", 32'({data_out, data_oe, busy, frame_done, frame_err}), 32'd0);

        // Basic frame: null bit, then 0xA5 MSB first, then DONE zero.
        run_frame(8'hA5, 8'hA5, 10, rx, oe_all);
        chk("a5_bits", 32'(rx[9:0]), 32'h14A);
        chk("a5_oe", 32'(oe_all), 32'd1);
        end_frame("a5");
        chk("a5_done", 32'(done_cnt), 32'd1);
        chk("a5_err", 32'(err_cnt), 32'd0);

        // Back-to-back all-zero and all-one samples.
        run_frame(8'h00, 8'h00, 10, rx, oe_all);
        chk("z_bits", 32'(rx[9:0]), 32'h000);
        end_frame("z");
        run_frame(8'hFF, 8'hFF, 10, rx, oe_all);
        chk("f_bits", 32'(rx[9:0]), 32'h1FE);
        chk("f_oe", 32'(oe_all), 32'd1);
        end_frame("f");
        chk("bb_done", 32'(done_cnt), 32'd3);
        chk("bb_err", 32'(err_cnt), 32'd0);

        // Aborted frame after four data bits of 0x3C.
        run_frame(8'h3C, 8'h3C, 5, rx, oe_all);
        chk("ab_bits", 32'(rx[4:0]), 32'h03);
        end_frame("ab");
        chk("ab_err", 32'(err_cnt), 32'd1);
        chk("ab_done", 32'(done_cnt), 32'd3);

        // Capture holds 0x81 despite change; extra clocks after LSB stay zero.
        run_frame(8'h81, 8'h7E, 11, rx, oe_all);
        chk("cap_bits", 32'(rx[10:0]), 32'h204);
        chk("cap_oe", 32'(oe_all), 32'd1);
        end_frame("cap");
        chk("cap_done", 32'(done_cnt), 32'd4);

        // Reset mid-frame while showing bit 5; cs_n held low must not restart.
        run_frame(8'hC3, 8'hC3, 4, rx, oe_all);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_outs", 32'({data_out, data_oe, busy, frame_done, frame_err}), 32'd0);
        wait_clk(2);
        reset_n = 1'b1;
        toggle_only(3, act);
        chk("rst_quiet", 32'(act), 32'd0);
        cs_n = 1'b1;
        wait_clk(HALF);
        run_frame(8'h5A, 8'h5A, 10, rx, oe_all);
        chk("rst_next_bits", 32'(rx[9:0]), 32'h0B4);
        end_frame("rst_next");
        chk("rst_done", 32'(done_cnt), 32'd5);
        chk("rst_err", 32'(err_cnt), 32'd1);

        // clk_adc activity with cs_n high.
        toggle_only(20, act);
        chk("idle_quiet", 32'(act), 32'd0);
        chk("idle_done", 32'(done_cnt), 32'd5);
        chk("idle_err", 32'(err_cnt), 32'd1);
        chk("pulse_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
